// File: rtl/ats_multi_timer.sv
// ats_multi_timer: NUM_CLOCKS programmable counters with prescaled tick rates,
// NUM_ALARMS alarm/countdown comparators with stretched fire pulses, sticky
// pending flags and an interrupt. Two clients program it through a shared
// two-beat 32-bit instruction transfer.
module ats_multi_timer #(
  parameter int NUM_CLOCKS  = 16,
  parameter int NUM_ALARMS  = 24,
  parameter int CNT_W       = 16,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [15:0]           ctrlA,
  input  logic [15:0]           ctrlB,
  output logic                  ready,
  output logic [1:0]            stat,
  output logic [NUM_ALARMS-1:0] data,
  output logic                  irq
);

  localparam int HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [5:0]    NC_L   = 6'(NUM_CLOCKS);
  localparam logic [5:0]    NA_L   = 6'(NUM_ALARMS);
  localparam logic [HW-1:0] HOLD_L = HW'(HOLD_CYCLES);

  localparam logic [2:0] OP_SETCLK = 3'b001;
  localparam logic [2:0] OP_CLKEN  = 3'b010;
  localparam logic [2:0] OP_MODE   = 3'b011;
  localparam logic [2:0] OP_SETALM = 3'b101;
  localparam logic [2:0] OP_CDOWN  = 3'b110;
  localparam logic [2:0] OP_ALMCTL = 3'b111;

  // Transfer / global control state
  logic        phase_q, phase_d;
  logic [15:0] upper_a_q, upper_a_d, upper_b_q, upper_b_d;
  logic        ready_q, ready_d;
  logic [1:0]  stat_q, stat_d;
  logic        active_q, active_d;
  logic [1:0]  perm_clk_q, perm_clk_d, perm_alm_q, perm_alm_d;
  logic [2:0]  p_q, p_d;

  // Per-clock state
  logic             clk_en_q   [NUM_CLOCKS];
  logic [1:0]       clk_rate_q [NUM_CLOCKS];
  logic [CNT_W-1:0] cnt_q      [NUM_CLOCKS];

  // Per-alarm state
  logic             alm_en_q  [NUM_ALARMS];
  logic             alm_rep_q [NUM_ALARMS];
  logic [3:0]       alm_clk_q [NUM_ALARMS];
  logic [CNT_W-1:0] alm_val_q [NUM_ALARMS];
  logic             match_q   [NUM_ALARMS];
  logic             pend_q    [NUM_ALARMS];
  logic [HW-1:0]    hold_q    [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] pend_vec;

  // Instruction decode
  logic [31:0]      ins_a, ins_b;
  logic             exec, ok_a, ok_b, conflict, ack_a, ack_b;
  logic             clk_op_a, clk_op_b, alm_op_a, alm_op_b, mode_a, mode_b;
  logic [CNT_W-1:0] base_a, base_b;
  logic [3:0]       rate_tick;
  logic             unused_bits;

  // Whether an instruction is legal on its own (index range, permission, active)
  function automatic logic ins_ok(input logic [2:0] op, input logic [4:0] idx,
                                  input logic [3:0] aclk, input logic pc,
                                  input logic pa, input logic act);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_SETCLK, OP_CLKEN: ok = act && pc && ({2'b00, idx[4:1]} < NC_L);
      OP_MODE:             ok = 1'b1;
      OP_SETALM, OP_CDOWN: ok = act && pa && ({1'b0, idx} < NA_L) && ({2'b00, aclk} < NC_L);
      OP_ALMCTL:           ok = act && pa && ({1'b0, idx} < NA_L);
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign ins_a = {upper_a_q, ctrlA};
  assign ins_b = {upper_b_q, ctrlB};
  assign exec  = req && phase_q;

  assign clk_op_a = (ins_a[31:29] == OP_SETCLK) || (ins_a[31:29] == OP_CLKEN);
  assign clk_op_b = (ins_b[31:29] == OP_SETCLK) || (ins_b[31:29] == OP_CLKEN);
  assign alm_op_a = ins_a[31] && (ins_a[30:29] != 2'b00);
  assign alm_op_b = ins_b[31] && (ins_b[30:29] != 2'b00);
  assign mode_a   = (ins_a[31:29] == OP_MODE);
  assign mode_b   = (ins_b[31:29] == OP_MODE);

  assign ok_a = ins_ok(ins_a[31:29], ins_a[28:24], ins_a[19:16], perm_clk_q[0], perm_alm_q[0], active_q);
  assign ok_b = ins_ok(ins_b[31:29], ins_b[28:24], ins_b[19:16], perm_clk_q[1], perm_alm_q[1], active_q);

  // Two clients touching the same resource cancel each other out entirely
  assign conflict = (clk_op_a && clk_op_b && (ins_a[28:25] == ins_b[28:25])) ||
                    (alm_op_a && alm_op_b && (ins_a[28:24] == ins_b[28:24])) ||
                    (mode_a && mode_b);

  assign ack_a = exec && ok_a && !conflict;
  assign ack_b = exec && ok_b && !conflict;

  assign unused_bits = ^{ins_a[21:20], ins_b[21:20], ins_a[15:0], ins_b[15:0]};

  assign rate_tick = {p_q == 3'd7, p_q[1:0] == 2'd3, p_q[0], 1'b1};

  // Current count of the clock each client's countdown refers to
  always_comb begin
    base_a = '0;
    base_b = '0;
    for (int j = 0; j < NUM_CLOCKS; j++) begin
      if (ins_a[19:16] == 4'(j)) base_a = cnt_q[j];
      if (ins_b[19:16] == 4'(j)) base_b = cnt_q[j];
    end
  end

  // Transfer phase, handshake, mode/permission and prescaler next state
  always_comb begin
    phase_d    = phase_q;
    upper_a_d  = upper_a_q;
    upper_b_d  = upper_b_q;
    active_d   = active_q;
    perm_clk_d = perm_clk_q;
    perm_alm_d = perm_alm_q;
    ready_d    = exec;
    stat_d     = {ack_b, ack_a};
    p_d        = active_q ? p_q + 3'd1 : p_q;
    if (!phase_q) begin
      if (req) begin
        phase_d   = 1'b1;
        upper_a_d = ctrlA;
        upper_b_d = ctrlB;
      end
    end else begin
      phase_d = 1'b0;
    end
    if (ack_a && mode_a) begin
      active_d      = ins_a[28];
      perm_clk_d[0] = ins_a[27];
      perm_alm_d[0] = ins_a[26];
    end
    if (ack_b && mode_b) begin
      active_d      = ins_b[28];
      perm_clk_d[1] = ins_b[27];
      perm_alm_d[1] = ins_b[26];
    end
  end

  // Global control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q    <= 1'b0;
      upper_a_q  <= '0;
      upper_b_q  <= '0;
      ready_q    <= 1'b0;
      stat_q     <= 2'b00;
      active_q   <= 1'b1;
      perm_clk_q <= 2'b11;
      perm_alm_q <= 2'b11;
      p_q        <= '0;
    end else begin
      phase_q    <= phase_d;
      upper_a_q  <= upper_a_d;
      upper_b_q  <= upper_b_d;
      ready_q    <= ready_d;
      stat_q     <= stat_d;
      active_q   <= active_d;
      perm_clk_q <= perm_clk_d;
      perm_alm_q <= perm_alm_d;
      p_q        <= p_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLOCKS; gi++) begin : g_clk
      logic             hit_a, hit_b, tick, en_d;
      logic [31:0]      sel;
      logic [1:0]       rate_d;
      logic [CNT_W-1:0] cnt_d;

      assign hit_a = ack_a && clk_op_a && (ins_a[28:25] == 4'(gi));
      assign hit_b = ack_b && clk_op_b && (ins_b[28:25] == 4'(gi));
      assign sel   = hit_a ? ins_a : ins_b;
      assign tick  = active_q && clk_en_q[gi] && rate_tick[clk_rate_q[gi]];

      // Counter advance; a load from an instruction overrides the increment
      always_comb begin
        en_d   = clk_en_q[gi];
        rate_d = clk_rate_q[gi];
        cnt_d  = tick ? cnt_q[gi] + CNT_W'(1) : cnt_q[gi];
        if (hit_a || hit_b) begin
          if (sel[31:29] == OP_SETCLK) begin
            en_d   = 1'b1;
            rate_d = sel[23:22];
            cnt_d  = sel[CNT_W-1:0];
          end else begin
            en_d = sel[23];
          end
        end
      end

      // Counter registers
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          clk_en_q[gi]   <= 1'b0;
          clk_rate_q[gi] <= 2'b00;
          cnt_q[gi]      <= '0;
        end else begin
          clk_en_q[gi]   <= en_d;
          clk_rate_q[gi] <= rate_d;
          cnt_q[gi]      <= cnt_d;
        end
      end
    end

    for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_alm
      logic             hit_a, hit_b, hit, match, fire;
      logic             en_d, rep_d, pend_d;
      logic [31:0]      sel;
      logic [CNT_W-1:0] base, cur, val_d;
      logic [3:0]       aclk_d;
      logic [HW-1:0]    hold_d;

      assign hit_a = ack_a && alm_op_a && (ins_a[28:24] == 5'(gi));
      assign hit_b = ack_b && alm_op_b && (ins_b[28:24] == 5'(gi));
      assign hit   = hit_a || hit_b;
      assign sel   = hit_a ? ins_a : ins_b;
      assign base  = hit_a ? base_a : base_b;

      // Count of the clock this alarm watches
      always_comb begin
        cur = '0;
        for (int j = 0; j < NUM_CLOCKS; j++) begin
          if (alm_clk_q[gi] == 4'(j)) cur = cnt_q[j];
        end
      end

      assign match = alm_en_q[gi] && (cur == alm_val_q[gi]);
      assign fire  = match && !match_q[gi] && active_q;

      // Alarm configuration, hold stretcher and pending flag next state
      always_comb begin
        en_d   = alm_en_q[gi];
        rep_d  = alm_rep_q[gi];
        aclk_d = alm_clk_q[gi];
        val_d  = alm_val_q[gi];
        pend_d = pend_q[gi];
        hold_d = (hold_q[gi] != '0) ? hold_q[gi] - HW'(1) : hold_q[gi];
        if (fire) begin
          hold_d = HOLD_L;
          if (!alm_rep_q[gi]) en_d = 1'b0;
        end
        if (hit) begin
          case (sel[31:29])
            OP_SETALM: begin
              en_d   = 1'b1;
              rep_d  = sel[23];
              aclk_d = sel[19:16];
              val_d  = sel[CNT_W-1:0];
            end
            OP_CDOWN: begin
              en_d   = 1'b1;
              rep_d  = 1'b0;
              aclk_d = sel[19:16];
              val_d  = base + sel[CNT_W-1:0];
            end
            default: begin
              en_d = sel[23];
              if (sel[22]) pend_d = 1'b0;
            end
          endcase
        end
        if (fire) pend_d = 1'b1;
      end

      // Alarm registers
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          alm_en_q[gi]  <= 1'b0;
          alm_rep_q[gi] <= 1'b0;
          alm_clk_q[gi] <= '0;
          alm_val_q[gi] <= '0;
          match_q[gi]   <= 1'b0;
          pend_q[gi]    <= 1'b0;
          hold_q[gi]    <= '0;
        end else begin
          alm_en_q[gi]  <= en_d;
          alm_rep_q[gi] <= rep_d;
          alm_clk_q[gi] <= aclk_d;
          alm_val_q[gi] <= val_d;
          match_q[gi]   <= match;
          pend_q[gi]    <= pend_d;
          hold_q[gi]    <= hold_d;
        end
      end

      assign data[gi]     = (hold_q[gi] != '0);
      assign pend_vec[gi] = pend_q[gi];
    end
  endgenerate

  assign ready = ready_q;
  assign stat  = stat_q;
  assign irq   = |pend_vec;

endmodule

// File: tb/tb_ats_multi_timer.sv
// Directed bench for ats_multi_timer: a default-size instance plus a small
// instance (8 clocks, 8 alarms, 4-bit counters) driven by the same stimulus.
module tb_ats_multi_timer;

  logic        clk;
  logic        reset;
  logic        req;
  logic [15:0] ctrlA;
  logic [15:0] ctrlB;
  logic        ready, ready4;
  logic [1:0]  stat, stat4;
  logic [23:0] data;
  logic [7:0]  data4;
  logic        irq, irq4;

  int checks = 0;
  int passes = 0;

  ats_multi_timer dut (
    .clk(clk), .reset(reset), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
    .ready(ready), .stat(stat), .data(data), .irq(irq)
  );

  ats_multi_timer #(.NUM_CLOCKS(8), .NUM_ALARMS(8), .CNT_W(4), .HOLD_CYCLES(2)) dut4 (
    .clk(clk), .reset(reset), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
    .ready(ready4), .stat(stat4), .data(data4), .irq(irq4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic xfer(input logic [31:0] a, input logic [31:0] b);
    req = 1'b1; ctrlA = a[31:16]; ctrlB = b[31:16];
    @(posedge clk); #1;
    ctrlA = a[15:0]; ctrlB = b[15:0];
    @(posedge clk); #1;
    req = 1'b0; ctrlA = '0; ctrlB = '0;
    $display("xfer A=%08h B=%08h -> ready=%b stat=%b ready4=%b stat4=%b", a, b, ready, stat, ready4, stat4);
  endtask

  task automatic do_reset();
    reset = 1'b0; req = 1'b0; ctrlA = '0; ctrlB = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b0; ctrlA = '0; ctrlB = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({ready, stat, data, irq} !== '0) $display("FAIL reset_in: got %h want 0", {ready, stat, data, irq}); else passes++;
    checks++; if ({ready4, stat4, data4, irq4} !== '0) $display("FAIL reset_in4: got %h want 0", {ready4, stat4, data4, irq4}); else passes++;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({ready, stat, data, irq} !== '0) $display("FAIL reset_out: got %h want 0", {ready, stat, data, irq}); else passes++;
    checks++; if (dut.cnt_q[3] !== 16'h0000) $display("FAIL reset_cnt: got %h want 0000", dut.cnt_q[3]); else passes++;
  endtask

  task automatic test_set_clock();
    xfer(32'h2600_0010, 32'h0);
    checks++; if (ready !== 1'b1 || stat !== 2'b01) $display("FAIL setclk_ack: got %b/%b want 1/01", ready, stat); else passes++;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0 || stat !== 2'b00) $display("FAIL setclk_ready_pulse: got %b/%b want 0/00", ready, stat); else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dut.cnt_q[3] !== 16'h0014) $display("FAIL setclk_count: got %h want 0014", dut.cnt_q[3]); else passes++;
  endtask

  task automatic test_countdown();
    int rise_n;
    int highs;
    xfer(32'h2480_0000, 32'h0);
    xfer(32'hC502_0003, 32'h0);
    checks++; if (stat !== 2'b01) $display("FAIL cdown_ack: got %b want 01", stat); else passes++;
    checks++; if (irq !== 1'b0) $display("FAIL cdown_irq_pre: got %b want 0", irq); else passes++;
    rise_n = -1;
    highs = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (data[5]) begin
        highs++;
        if (rise_n < 0) rise_n = n;
      end
    end
    checks++; if (rise_n < 6 || rise_n > 14) $display("FAIL cdown_rise: got cycle %0d want 6..14", rise_n); else passes++;
    checks++; if (highs !== 2) $display("FAIL cdown_width: got %0d want 2", highs); else passes++;
    checks++; if (irq !== 1'b1) $display("FAIL cdown_irq: got %b want 1", irq); else passes++;
    checks++; if (dut.alm_en_q[5] !== 1'b0) $display("FAIL cdown_oneshot: got %b want 0", dut.alm_en_q[5]); else passes++;
    xfer(32'hE540_0000, 32'h0);
    checks++; if (stat !== 2'b01 || irq !== 1'b0) $display("FAIL cdown_clear: got stat=%b irq=%b want 01/0", stat, irq); else passes++;
    highs = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (data[5]) highs++;
    end
    checks++; if (highs !== 0) $display("FAIL cdown_quiet: got %0d want 0", highs); else passes++;
  endtask

  task automatic test_repeat();
    int rises [3];
    int nr;
    int highs;
    logic prev;
    do_reset();
    xfer(32'h2000_0000, 32'hA080_0000);
    checks++; if (stat4 !== 2'b11) $display("FAIL rep_ack: got %b want 11", stat4); else passes++;
    nr = 0; highs = 0; prev = 1'b0;
    rises[0] = -1; rises[1] = -1; rises[2] = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (data4[0]) highs++;
      if (data4[0] && !prev && nr < 3) begin
        rises[nr] = n;
        nr++;
      end
      prev = data4[0];
    end
    checks++; if (rises[0] !== 1 || rises[1] !== 17 || rises[2] !== 33) $display("FAIL rep_period: got %0d,%0d,%0d want 1,17,33", rises[0], rises[1], rises[2]); else passes++;
    checks++; if (highs !== 6) $display("FAIL rep_highs: got %0d want 6", highs); else passes++;
  endtask

  task automatic test_conflict();
    xfer(32'hA700_0005, 32'hA700_0006);
    checks++; if (stat !== 2'b00 || ready !== 1'b1) $display("FAIL conf_alarm: got %b/%b want 1/00", ready, stat); else passes++;
    checks++; if (dut.alm_en_q[7] !== 1'b0) $display("FAIL conf_applied: got %b want 0", dut.alm_en_q[7]); else passes++;
    xfer(32'h2200_0000, 32'h2400_0000);
    checks++; if (stat !== 2'b11) $display("FAIL conf_diff_clocks: got %b want 11", stat); else passes++;
    xfer(32'h2600_0000, 32'h4680_0000);
    checks++; if (stat !== 2'b00) $display("FAIL conf_same_clock: got %b want 00", stat); else passes++;
    xfer(32'h7C00_0000, 32'h7C00_0000);
    checks++; if (stat !== 2'b00) $display("FAIL conf_mode: got %b want 00", stat); else passes++;
  endtask

  task automatic test_perm();
    xfer(32'h7400_0000, 32'h0);
    checks++; if (stat !== 2'b01) $display("FAIL perm_mode: got %b want 01", stat); else passes++;
    xfer(32'h2800_0000, 32'h2A00_0000);
    checks++; if (stat !== 2'b10) $display("FAIL perm_setclk: got %b want 10", stat); else passes++;
    xfer(32'h0, 32'h6C00_0000);
    checks++; if (stat !== 2'b10 || dut.cnt_q[5] !== 16'd2) $display("FAIL perm_freeze: got stat=%b cnt=%0d want 10/2", stat, dut.cnt_q[5]); else passes++;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (dut.cnt_q[5] !== 16'd2) $display("FAIL perm_frozen: got %0d want 2", dut.cnt_q[5]); else passes++;
    xfer(32'h0, 32'h2C00_0000);
    checks++; if (stat !== 2'b00) $display("FAIL perm_inactive: got %b want 00", stat); else passes++;
    xfer(32'h0, 32'h7C00_0000);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dut.cnt_q[5] !== 16'd5) $display("FAIL perm_resume: got %0d want 5", dut.cnt_q[5]); else passes++;
  endtask

  task automatic test_index();
    do_reset();
    xfer(32'h3E00_0000, 32'h0);
    checks++; if (stat !== 2'b01 || stat4 !== 2'b00) $display("FAIL idx_clock15: got %b/%b want 01/00", stat, stat4); else passes++;
    xfer(32'hB800_0000, 32'h8000_0000);
    checks++; if (stat !== 2'b00) $display("FAIL idx_alarm24_op100: got %b want 00", stat); else passes++;
    xfer(32'hB700_0005, 32'h0);
    checks++; if (stat !== 2'b01 || stat4 !== 2'b00) $display("FAIL idx_alarm23: got %b/%b want 01/00", stat, stat4); else passes++;
  endtask

  task automatic test_abort();
    int seen;
    req = 1'b1; ctrlA = 16'h2200; ctrlB = 16'h0000;
    @(posedge clk); #1;
    req = 1'b0; ctrlA = '0;
    seen = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (ready) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL abort_ready: got %0d pulses want 0", seen); else passes++;
    xfer(32'h2200_0000, 32'h0);
    checks++; if (ready !== 1'b1 || stat !== 2'b01) $display("FAIL abort_next: got %b/%b want 1/01", ready, stat); else passes++;
  endtask

  task automatic test_reset_mid();
    req = 1'b1; ctrlA = 16'h6000; ctrlB = 16'h6000;
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    #2;
    checks++; if (ready !== 1'b0 || stat !== 2'b00) $display("FAIL rstmid_outs: got %b/%b want 0/00", ready, stat); else passes++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    req = 1'b1; ctrlA = 16'h2200; ctrlB = 16'h0000;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) $display("FAIL rstmid_beat1: got %b want 0", ready); else passes++;
    ctrlA = 16'h0000;
    @(posedge clk); #1;
    req = 1'b0;
    checks++; if (ready !== 1'b1 || stat !== 2'b01) $display("FAIL rstmid_ack: got %b/%b want 1/01", ready, stat); else passes++;
  endtask

  task automatic test_back_to_back();
    xfer(32'h2200_0000, 32'h0);
    checks++; if (ready !== 1'b1 || stat !== 2'b01) $display("FAIL b2b_first: got %b/%b want 1/01", ready, stat); else passes++;
    req = 1'b1; ctrlA = 16'h2C00; ctrlB = 16'h2E00;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) $display("FAIL b2b_gap: got %b want 0", ready); else passes++;
    ctrlA = 16'h0000; ctrlB = 16'h0000;
    @(posedge clk); #1;
    req = 1'b0;
    checks++; if (ready !== 1'b1 || stat !== 2'b11) $display("FAIL b2b_second: got %b/%b want 1/11", ready, stat); else passes++;
  endtask

  initial begin
    test_reset();
    test_set_clock();
    test_countdown();
    test_repeat();
    test_conflict();
    test_perm();
    test_index();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
